sdram_fill_engine: RTL and testbench
====================================

SDRAM_FILL_ENGINE -- requirements
Module: sdram_fill_engine

Interface
REQ-001 SHALL have parameter ADDR_W, 29, Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, 64, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter BURST_LEN, 8, maximum beats per burst (1..128).
REQ-004 SHALL have port clk  in  1  system clock (100 MHz).
REQ-005 SHALL have port reset_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports start  in  1  one-cycle launch strobe; base_addr  in  ADDR_W  first word address; length  in  ADDR_W  word count.
REQ-007 SHALL have ports mode  in  2  pattern select; seed  in  DATA_W  pattern seed.
REQ-008 SHALL have ports busy  out  1; done  out  1  one-cycle pulse; error_count  out  32; first_err_addr  out  ADDR_W.
REQ-009 SHALL have Avalon-MM master ports avm_address out ADDR_W, avm_burstcount out 8, avm_byteenable out DATA_W/8 (all ones), avm_write out 1, avm_writedata out DATA_W, avm_read out 1, avm_readdata in DATA_W, avm_readdatavalid in 1, avm_waitrequest in 1.

Function
REQ-010 SHALL latch base_addr, length, mode and seed on start in IDLE; start while busy is ignored.
REQ-011 SHALL generate pattern word for index i: mode 0 seed; mode 1 seed+i (mod 2^DATA_W); mode 2 seed for even i, ~seed for odd i; mode 3 address zero-extended to DATA_W.
REQ-012 SHALL use states IDLE, WR_BURST, RD_CMD, RD_DATA, DONE.
REQ-013 SHALL issue writes in bursts of burstcount = min(remaining, BURST_LEN); address and burstcount held constant for the whole burst.
REQ-014 SHALL hold avm_write, avm_writedata, avm_address while avm_waitrequest is high; a beat is accepted only in a cycle with write high and waitrequest low.
REQ-015 SHALL advance to the next burst address (+burstcount) after the last beat accepted, with no idle cycle between bursts.
REQ-016 SHALL wrap addresses modulo 2^ADDR_W.
REQ-017 SHALL, for length = 0, go IDLE->DONE with no bus transactions and pulse done one cycle after start.
REQ-018 SHALL (verify enabled) after all writes, issue one read per burst with same burstcount, hold avm_read until waitrequest low, then wait in RD_DATA for burstcount readdatavalid beats before next read command.
REQ-019 SHALL compare each readdatavalid beat with the expected pattern; on mismatch increment error_count (saturating at 0xFFFF_FFFF) and capture first_err_addr on the first mismatch only.
REQ-020 SHALL ignore readdatavalid outside RD_DATA.
REQ-021 SHALL assert busy from the cycle after start through DONE; done pulses exactly one cycle in DONE, then IDLE.
REQ-022 SHALL clear error_count and first_err_addr on each accepted start; results hold until next start.

Reset
REQ-023 SHALL, with reset_n low at a clock edge, set state IDLE, avm_write 0, avm_read 0, avm_address 0, avm_burstcount 0, avm_writedata 0, busy 0, done 0, error_count 0, first_err_addr 0.
REQ-024 SHALL abandon any in-flight burst on reset without completing it; no done pulse.

Configuration
REQ-025 SHALL compile read-back verify (RD_CMD, RD_DATA, comparison) only when SDRAM_FILL_VERIFY_EN is defined; otherwise WR_BURST goes directly to DONE, avm_read is tied 0, error_count and first_err_addr are tied 0.

Structure
REQ-026 SHALL place the state enum and mode encodings (MODE_CONST, MODE_INCR, MODE_ALT, MODE_ADDR) in shared package sdram_fill_pkg.
REQ-027 SHALL implement pattern generation in sub-module sdram_fill_pattern (inputs mode, seed, index, address; combinational data out), instantiated once for writes and once for compares.

Verification
REQ-028 SHALL cover: base 0x0700_0000, length 16, mode 0, seed 0xDEAD_BEEF_CAFE_BABE, no waitrequest -> two 8-beat bursts at 0x0700_0000 and 0x0700_0008, done pulse, error_count 0.
REQ-029 SHALL cover: length 11, mode 1, seed 0 -> bursts of 8 then 3; beat data 0..10.
REQ-030 SHALL cover: random waitrequest 50% -> avm outputs stable while stalled, all 16 beats written exactly once.
REQ-031 SHALL cover: memory model corrupts word 0x0700_0005 -> error_count 1, first_err_addr 0x0700_0005.
REQ-032 SHALL cover: base 0x1FFF_FFFC (ADDR_W 29), length 8, mode 3 -> addresses wrap to 0 after 0x1FFF_FFFF.
REQ-033 SHALL cover: reset_n low mid-burst beat 4 -> next cycle avm_write 0, busy 0; new start runs cleanly.

Source files
------------

// File: rtl/sdram_fill_pkg.sv
// sdram_fill_pkg: shared state encoding and pattern mode codes for the
// SDRAM fill engine and its pattern generator.
package sdram_fill_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        RD_CMD   = 3'd2,
        RD_DATA  = 3'd3,
        DONE     = 3'd4
    } fill_state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;  // every word = seed
    localparam logic [1:0] MODE_INCR  = 2'd1;  // seed + index
    localparam logic [1:0] MODE_ALT   = 2'd2;  // seed / ~seed alternating
    localparam logic [1:0] MODE_ADDR  = 2'd3;  // word address zero-extended

endpackage

// File: rtl/sdram_fill_pattern.sv
// sdram_fill_pattern: combinational pattern word for a given beat index and
// word address. Used both for write data and for read-back comparison.
module sdram_fill_pattern
    import sdram_fill_pkg::*;
#(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] index,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    // Select the pattern word; arithmetic wraps modulo 2^DATA_W.
    always_comb begin
        data = seed;
        case (mode)
            MODE_CONST: data = seed;
            MODE_INCR:  data = seed + DATA_W'(index);
            MODE_ALT:   data = index[0] ? ~seed : seed;
            MODE_ADDR:  data = DATA_W'(address);
            default:    data = seed;
        endcase
    end

endmodule

// File: rtl/sdram_fill_engine.sv
// sdram_fill_engine: writes a generated pattern over a word range through an
// Avalon-MM burst master. When SDRAM_FILL_VERIFY_EN is defined the range is
// read back burst by burst and mismatches are counted; otherwise the engine
// is write-only and the error outputs are tied to zero.
module sdram_fill_engine
    import sdram_fill_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [31:0]         error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [7:0]          avm_burstcount,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_read,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                avm_waitrequest
);

    localparam logic [ADDR_W-1:0] ONE_W = ADDR_W'(1);

    fill_state_t       state_q, state_d;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] burst_addr_q;  // start address of the current burst
    logic [ADDR_W-1:0] rem_q;         // words left, current burst included
    logic [ADDR_W-1:0] cur_idx_q;     // pattern index of the next beat
    logic [ADDR_W-1:0] cur_addr_q;    // word address of the next beat
    logic [ADDR_W-1:0] rem_after;
    logic [7:0]        bc_q;
    logic [7:0]        beat_q;        // beats done within the current burst
    logic              launch;
    logic              wr_fire;
    logic              rd_fire;
    logic              beat_fire;
    logic              last_beat;

    // Burst size for a given number of outstanding words.
    function automatic logic [7:0] burst_of(input logic [ADDR_W-1:0] words);
        if (words < ADDR_W'(BURST_LEN))
            return words[7:0];
        return 8'(BURST_LEN);
    endfunction

    assign launch         = (state_q == IDLE) && start;
    assign wr_fire        = (state_q == WR_BURST) && !avm_waitrequest;
    assign beat_fire      = wr_fire || rd_fire;
    assign last_beat      = beat_fire && (beat_q == bc_q - 8'd1);
    assign rem_after      = rem_q - ADDR_W'(bc_q);

    assign avm_address    = burst_addr_q;
    assign avm_burstcount = bc_q;
    assign avm_byteenable = '1;

    sdram_fill_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
        .mode    (mode_q),
        .seed    (seed_q),
        .index   (cur_idx_q),
        .address (cur_addr_q),
        .data    (avm_writedata)
    );

`ifdef SDRAM_FILL_VERIFY_EN
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [31:0]       err_cnt_q;
    logic [ADDR_W-1:0] first_err_q;
    logic [DATA_W-1:0] cmp_data;

    // Read data only counts while waiting for beats of an issued read.
    assign rd_fire = (state_q == RD_DATA) && avm_readdatavalid;

    sdram_fill_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_pat (
        .mode    (mode_q),
        .seed    (seed_q),
        .index   (cur_idx_q),
        .address (cur_addr_q),
        .data    (cmp_data)
    );

    // Keep the original range so the read pass can rewind to it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (launch) begin
            base_q <= base_addr;
            len_q  <= length;
        end
    end

    // Saturating mismatch counter; the first failing address is kept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (launch) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (rd_fire && (cmp_data != avm_readdata)) begin
            if (err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 32'd1;
            if (err_cnt_q == '0)
                first_err_q <= cur_addr_q;
        end
    end

    assign error_count    = err_cnt_q;
    assign first_err_addr = first_err_q;
`else
    logic unused_rd;

    assign rd_fire        = 1'b0;
    assign error_count    = '0;
    assign first_err_addr = '0;
    assign unused_rd      = &{1'b0, avm_readdata, avm_readdatavalid};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and bus strobes; a finished burst rolls straight into the next.
    always_comb begin
        state_d   = state_q;
        avm_write = 1'b0;
        avm_read  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = (length == '0) ? DONE : WR_BURST;
            end
            WR_BURST: begin
                avm_write = 1'b1;
                if (last_beat && (rem_after == '0))
`ifdef SDRAM_FILL_VERIFY_EN
                    state_d = RD_CMD;
`else
                    state_d = DONE;
`endif
            end
`ifdef SDRAM_FILL_VERIFY_EN
            RD_CMD: begin
                avm_read = 1'b1;
                if (!avm_waitrequest)
                    state_d = RD_DATA;
            end
            RD_DATA: begin
                if (last_beat)
                    state_d = (rem_after == '0) ? DONE : RD_CMD;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst/beat bookkeeping shared by the write and read passes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q       <= MODE_CONST;
            seed_q       <= '0;
            burst_addr_q <= '0;
            rem_q        <= '0;
            cur_idx_q    <= '0;
            cur_addr_q   <= '0;
            bc_q         <= '0;
            beat_q       <= '0;
        end else if (launch) begin
            mode_q       <= mode;
            seed_q       <= seed;
            burst_addr_q <= base_addr;
            cur_addr_q   <= base_addr;
            cur_idx_q    <= '0;
            rem_q        <= length;
            bc_q         <= burst_of(length);
            beat_q       <= '0;
        end else if (beat_fire) begin
            cur_idx_q  <= cur_idx_q + ONE_W;
            cur_addr_q <= cur_addr_q + ONE_W;
            beat_q     <= beat_q + 8'd1;
            if (last_beat) begin
                beat_q       <= '0;
                burst_addr_q <= burst_addr_q + ADDR_W'(bc_q);
                rem_q        <= rem_after;
                bc_q         <= burst_of(rem_after);
`ifdef SDRAM_FILL_VERIFY_EN
                if (wr_fire && (rem_after == '0)) begin
                    burst_addr_q <= base_q;
                    cur_addr_q   <= base_q;
                    cur_idx_q    <= '0;
                    rem_q        <= len_q;
                    bc_q         <= burst_of(len_q);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sdram_fill_engine.sv
// tb_sdram_fill_engine: directed scoreboard bench for sdram_fill_engine with
// a small Avalon memory slave (optional random waitrequest, one corruptible
// word on read-back).
module tb_sdram_fill_engine;

`ifdef SDRAM_FILL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct { logic [28:0] a; logic [63:0] d; } beat_t;
    typedef struct { logic [28:0] a; logic [7:0] bc; } burst_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [28:0] base_addr = '0;
    logic [28:0] length = '0;
    logic [1:0]  mode = '0;
    logic [63:0] seed = '0;
    logic        busy, done;
    logic [31:0] error_count;
    logic [28:0] first_err_addr;
    logic [28:0] avm_address;
    logic [7:0]  avm_burstcount;
    logic [7:0]  avm_byteenable;
    logic        avm_write, avm_read;
    logic [63:0] avm_writedata;
    logic [63:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int read_seen = 0;
    int beats_run = 0;
    int extra = 0;
    bit rand_wait = 1'b0;
    bit corrupt_en = 1'b0;
    logic [28:0] corrupt_addr = '0;

    beat_t  exp_beats[$];
    burst_t exp_wr[$];
    burst_t exp_rd[$];
    burst_t rd_q[$];
    logic [63:0] mem [logic [28:0]];

    always #5 clk = ~clk;

    sdram_fill_engine #(.ADDR_W(29), .DATA_W(64), .BURST_LEN(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .mode              (mode),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .error_count       (error_count),
        .first_err_addr    (first_err_addr),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_byteenable    (avm_byteenable),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [1:0] m, input logic [63:0] s,
                                        input int i, input logic [28:0] a);
        case (m)
            2'd0:    return s;
            2'd1:    return s + 64'(i);
            2'd2:    return (i % 2 == 1) ? ~s : s;
            default: return {35'd0, a};
        endcase
    endfunction

    function automatic logic [63:0] mem_rd(input logic [28:0] a);
        logic [63:0] v;
        v = mem.exists(a) ? mem[a] : 64'd0;
        if (corrupt_en && a == corrupt_addr)
            v = v ^ 64'h1;
        return v;
    endfunction

    // Bus monitor: sampled mid-cycle, describes what the next edge accepts.
    logic [28:0] sv_a;
    logic [7:0]  sv_bc;
    logic [63:0] sv_d;
    logic [1:0]  sv_ctl;
    bit          stalled = 1'b0;
    int          mon_beat = 0;
    initial begin : monitor
        beat_t  e;
        burst_t b;
        logic [28:0] a;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (avm_read) read_seen++;
            if (!reset_n) begin
                mon_beat = 0;
                stalled  = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_addr", 64'(avm_address), 64'(sv_a));
                    check("stall_bc", 64'(avm_burstcount), 64'(sv_bc));
                    check("stall_data", avm_writedata, sv_d);
                    check("stall_ctl", 64'({avm_write, avm_read}), 64'(sv_ctl));
                end
                stalled = (avm_write || avm_read) && avm_waitrequest;
                sv_a = avm_address; sv_bc = avm_burstcount;
                sv_d = avm_writedata; sv_ctl = {avm_write, avm_read};
                if (avm_write && !avm_waitrequest) begin
                    if (mon_beat == 0) begin
                        if (exp_wr.size() == 0) extra++;
                        else begin
                            b = exp_wr.pop_front();
                            check("wr_burst_addr", 64'(avm_address), 64'(b.a));
                            check("wr_burst_bc", 64'(avm_burstcount), 64'(b.bc));
                        end
                    end
                    a = avm_address + 29'(mon_beat);
                    if (exp_beats.size() == 0) extra++;
                    else begin
                        e = exp_beats.pop_front();
                        check("wr_addr", 64'(a), 64'(e.a));
                        check("wr_data", avm_writedata, e.d);
                    end
                    mem[a] = avm_writedata;
                    beats_run++;
                    mon_beat++;
                    if (mon_beat >= int'(avm_burstcount)) mon_beat = 0;
                end
                if (avm_read && !avm_waitrequest) begin
                    if (exp_rd.size() == 0) extra++;
                    else begin
                        b = exp_rd.pop_front();
                        check("rd_burst_addr", 64'(avm_address), 64'(b.a));
                        check("rd_burst_bc", 64'(avm_burstcount), 64'(b.bc));
                    end
                    b.a = avm_address; b.bc = avm_burstcount;
                    rd_q.push_back(b);
                end
            end
        end
    end

    // Slave responder: waitrequest and read data, driven just after each edge.
    initial begin : responder
        burst_t      b;
        logic [28:0] rd_addr = '0;
        int          rd_left = 0;
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rd_left == 0 && rd_q.size() > 0) begin
                b = rd_q.pop_front();
                rd_addr = b.a;
                rd_left = int'(b.bc);
            end
            if (rd_left > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = mem_rd(rd_addr);
                rd_addr = rd_addr + 29'd1;
                rd_left--;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = '1;
            end
        end
    end

    task automatic expect_run(input logic [28:0] base, input logic [28:0] len,
                              input logic [1:0] m, input logic [63:0] s);
        beat_t  e;
        burst_t b;
        logic [28:0] rem;
        for (int i = 0; i < int'(len); i++) begin
            e.a = base + 29'(i);
            e.d = pat(m, s, i, e.a);
            exp_beats.push_back(e);
        end
        rem = len;
        b.a = base;
        while (rem != 0) begin
            b.bc = (rem < 29'd8) ? rem[7:0] : 8'd8;
            exp_wr.push_back(b);
            if (VERIFY) exp_rd.push_back(b);
            b.a = b.a + 29'(b.bc);
            rem = rem - 29'(b.bc);
        end
    endtask

    task automatic kick(input logic [28:0] base, input logic [28:0] len,
                        input logic [1:0] m, input logic [63:0] s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = len; mode = m; seed = s;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on_start", 64'(busy), 64'd1);
        if (len > 29'd4) begin
            // a start while busy must change nothing
            start = 1'b1; base_addr = 29'h0000123; length = 29'd3; mode = ~m; seed = ~s;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic finish_run(input logic [31:0] exp_err, input logic [28:0] exp_first,
                              input int d0, input int x0);
        bit got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", 64'(got), 64'd1);
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        check("beats_left", 64'(exp_beats.size()), 64'd0);
        check("bursts_left", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
        check("extra_xfers", 64'(extra - x0), 64'd0);
        check("err_count", 64'(error_count), 64'(exp_err));
        check("first_err", 64'(first_err_addr), 64'(exp_first));
        exp_beats.delete(); exp_wr.delete(); exp_rd.delete();
    endtask

    task automatic run(input logic [28:0] base, input logic [28:0] len, input logic [1:0] m,
                       input logic [63:0] s, input logic [31:0] exp_err, input logic [28:0] exp_first);
        int d0, x0;
        d0 = done_cnt;
        x0 = extra;
        expect_run(base, len, m, s);
        kick(base, len, m, s);
        finish_run(exp_err, exp_first, d0, x0);
    endtask

    initial begin : main
        int  b0, d0;
        bit  got;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_read", 64'(avm_read), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_bc", 64'(avm_burstcount), 64'd0);
        check("rst_wdata", avm_writedata, 64'd0);
        check("rst_errcnt", 64'(error_count), 64'd0);
        check("rst_firsterr", 64'(first_err_addr), 64'd0);
        check("byteenable", 64'(avm_byteenable), 64'hFF);
        reset_n = 1'b1;

        // constant seed, two full bursts
        run(29'h0700_0000, 29'd16, 2'd0, 64'hDEAD_BEEF_CAFE_BABE, 32'd0, 29'd0);
        // incrementing, 8 + 3 beats
        run(29'h0100_0000, 29'd11, 2'd1, 64'd0, 32'd0, 29'd0);
        // alternating under random stalls
        rand_wait = 1'b1;
        run(29'h0200_0010, 29'd16, 2'd2, 64'h0123_4567_89AB_CDEF, 32'd0, 29'd0);
        rand_wait = 1'b0;
        // one corrupted word on read-back
        corrupt_en = 1'b1;
        corrupt_addr = 29'h0700_0005;
        run(29'h0700_0000, 29'd16, 2'd1, 64'h55AA_0000_1234_0000,
            VERIFY ? 32'd1 : 32'd0, VERIFY ? 29'h0700_0005 : 29'd0);
        corrupt_en = 1'b0;
        // address pattern across the top of the address space
        run(29'h1FFF_FFFC, 29'd8, 2'd3, 64'd0, 32'd0, 29'd0);

        // zero length: done one cycle after start, no transfers
        b0 = beats_run;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 29'h0400_0000; length = 29'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd1);
        check("len0_write", 64'(avm_write), 64'd0);
        @(posedge clk); #1;
        check("len0_done_clr", 64'(done), 64'd0);
        check("len0_idle", 64'(busy), 64'd0);
        check("len0_beats", 64'(beats_run - b0), 64'd0);

        // reset in the middle of a burst
        b0 = beats_run;
        d0 = done_cnt;
        expect_run(29'h0300_0000, 29'd16, 2'd0, 64'hAAAA_5555_AAAA_5555);
        kick(29'h0300_0000, 29'd16, 2'd0, 64'hAAAA_5555_AAAA_5555);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            if (beats_run - b0 >= 4) got = 1'b1;
        end
        check("reached_beat4", 64'(got), 64'd1);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_write", 64'(avm_write), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_addr", 64'(avm_address), 64'd0);
        reset_n = 1'b1;
        exp_beats.delete(); exp_wr.delete(); exp_rd.delete();
        repeat (3) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        run(29'h0300_0040, 29'd16, 2'd1, 64'h0000_0000_0000_1000, 32'd0, 29'd0);

        check("reads_seen", 64'(read_seen > 0), 64'(VERIFY));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
